// File: rtl/clock_group_reset_source.sv
// clock_group_reset_source: produces the clock/reset/clock_en bundle for the cbus clock group
// Ports:
//   clock, reset (async active-low)         block clock and chip-level reset
//   io_swReset_req / io_swReset_ack         software member-domain reset handshake
//   io_gate_req, io_quiescent / io_gate_ack quiescence-qualified clock-enable gating
//   io_state                                FSM state (ASSERT=0, HOLD=1, RUN=2, GATED=3)
//   auto_out_member_subsystem_cbus_0_*      member clock (pass-through), reset (active-high), clock_en
module clock_group_reset_source #(
    parameter int SYNC_STAGES = 3,
    parameter int RESET_HOLD  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_swReset_req,
    output logic       io_swReset_ack,
    input  logic       io_gate_req,
    input  logic       io_quiescent,
    output logic       io_gate_ack,
    output logic [1:0] io_state,
    output logic       auto_out_member_subsystem_cbus_0_clock,
    output logic       auto_out_member_subsystem_cbus_0_reset,
    output logic       auto_out_member_subsystem_cbus_0_clock_en
);
    typedef enum logic [1:0] {ASSERT = 2'd0, HOLD = 2'd1, RUN = 2'd2, GATED = 2'd3} state_e;
    localparam logic [7:0] HOLD_LOAD = 8'(RESET_HOLD - 1);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;
    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   ack_q, ack_d;
    logic                   sw_take;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
    assign rst_sync = sync_q[SYNC_STAGES-1];
    // A request is not re-accepted while its ack is still being held.
    assign sw_take = io_swReset_req & ~ack_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ack_d   = ack_q & io_swReset_req;
        case (state_q)
            ASSERT: if (rst_sync) begin
                state_d = HOLD;
                cnt_d   = HOLD_LOAD;
            end
            HOLD: if (cnt_q == '0) begin
                state_d = RUN;
                pend_d  = 1'b0;
                ack_d   = pend_q & io_swReset_req;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            RUN: if (sw_take) begin
                state_d = HOLD;
                cnt_d   = HOLD_LOAD;
                pend_d  = 1'b1;
            end else if (io_gate_req & io_quiescent) begin
                state_d = GATED;
            end
            GATED: if (sw_take) begin
                state_d = HOLD;
                cnt_d   = HOLD_LOAD;
                pend_d  = 1'b1;
            end else if (!io_gate_req) begin
                state_d = RUN;
            end
            default: state_d = ASSERT;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
        end
    end
    // Outputs decode only from flops, so they cannot glitch on input changes.
    assign io_state                                  = state_q;
    assign io_swReset_ack                            = ack_q;
    assign io_gate_ack                               = state_q == GATED;
    assign auto_out_member_subsystem_cbus_0_clock    = clock;
    assign auto_out_member_subsystem_cbus_0_reset    = ~state_q[1];
    assign auto_out_member_subsystem_cbus_0_clock_en = state_q != GATED;
endmodule

// File: tb/tb_clock_group_reset_source.sv
// tb_clock_group_reset_source: scoreboard bench for the default and minimal parameter sets
module tb_clock_group_reset_source;
  logic clk = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst_a = 1'b0, sw_a = 1'b0, gate_a = 1'b0, quies_a = 1'b0;
  logic sack_a, gack_a, mclk_a, mrst_a, en_a;
  logic [1:0] st_a;
  logic rst_b = 1'b0, sw_b = 1'b0;
  logic sack_b, gack_b, mclk_b, mrst_b, en_b;
  logic [1:0] st_b;
  clock_group_reset_source dut (
    .clock(clk), .reset(rst_a),
    .io_swReset_req(sw_a), .io_swReset_ack(sack_a),
    .io_gate_req(gate_a), .io_quiescent(quies_a), .io_gate_ack(gack_a),
    .io_state(st_a),
    .auto_out_member_subsystem_cbus_0_clock(mclk_a),
    .auto_out_member_subsystem_cbus_0_reset(mrst_a),
    .auto_out_member_subsystem_cbus_0_clock_en(en_a)
  );
  clock_group_reset_source #(.SYNC_STAGES(2), .RESET_HOLD(1)) dut_min (
    .clock(clk), .reset(rst_b),
    .io_swReset_req(sw_b), .io_swReset_ack(sack_b),
    .io_gate_req(1'b0), .io_quiescent(1'b0), .io_gate_ack(gack_b),
    .io_state(st_b),
    .auto_out_member_subsystem_cbus_0_clock(mclk_b),
    .auto_out_member_subsystem_cbus_0_reset(mrst_b),
    .auto_out_member_subsystem_cbus_0_clock_en(en_b)
  );
  typedef struct {
    int id;
    int cyc;
    string name;
    logic [5:0] vec;
  } exp_t;
  exp_t q[$];
  task automatic expect_at(input int id, input int c, input string nm,
                           input logic r, input logic e, input logic g,
                           input logic s, input logic [1:0] st);
    exp_t x;
    x.id = id; x.cyc = c; x.name = nm; x.vec = {r, e, g, s, st};
    q.push_back(x);
  endtask
  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask
  task automatic report(input string nm, input int id, input int c,
                        input logic [5:0] got, input logic [5:0] want);
    $display("FAIL %s dut%0d cyc%0d: got rst=%b en=%b gack=%b sack=%b st=%0d, want rst=%b en=%b gack=%b sack=%b st=%0d",
             nm, id, c, got[5], got[4], got[3], got[2], got[1:0],
             want[5], want[4], want[3], want[2], want[1:0]);
  endtask
  task automatic check_clk(input string nm);
    checks++;
    if (mclk_a !== clk) begin
      errors++;
      $display("FAIL %s dut0: got clock=%b, want %b", nm, mclk_a, clk);
    end
    checks++;
    if (mclk_b !== clk) begin
      errors++;
      $display("FAIL %s dut1: got clock=%b, want %b", nm, mclk_b, clk);
    end
  endtask
  always @(negedge clk) begin
    logic [5:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act = (q[i].id == 0) ? {mrst_a, en_a, gack_a, sack_a, st_a}
                             : {mrst_b, en_b, gack_b, sack_b, st_b};
        checks++;
        if (q[i].cyc < cyc || act !== q[i].vec) begin
          errors++;
          report(q[i].name, q[i].id, q[i].cyc, act, q[i].vec);
        end
        q.delete(i);
      end
    end
  end
  initial begin
    expect_at(0, 1,  "reset_state",  1, 1, 0, 0, 2'd0);
    expect_at(0, 2,  "reset_state2", 1, 1, 0, 0, 2'd0);
    expect_at(0, 5,  "po_assert",    1, 1, 0, 0, 2'd0);
    expect_at(0, 6,  "po_hold",      1, 1, 0, 0, 2'd1);
    expect_at(0, 21, "po_hold_end",  1, 1, 0, 0, 2'd1);
    expect_at(0, 22, "po_run",       0, 1, 0, 0, 2'd2);
    at_edge(2);
    rst_a = 1'b1;
    at_edge(30);
    sw_a = 1'b1;
    expect_at(0, 30, "sw_pre",       0, 1, 0, 0, 2'd2);
    expect_at(0, 31, "sw_hold",      1, 1, 0, 0, 2'd1);
    expect_at(0, 46, "sw_hold_end",  1, 1, 0, 0, 2'd1);
    expect_at(0, 47, "sw_ack",       0, 1, 0, 1, 2'd2);
    expect_at(0, 50, "sw_no_retrig", 0, 1, 0, 1, 2'd2);
    expect_at(0, 52, "sw_ack_held",  0, 1, 0, 1, 2'd2);
    expect_at(0, 53, "sw_ack_clr",   0, 1, 0, 0, 2'd2);
    at_edge(52);
    sw_a = 1'b0;
    at_edge(55);
    gate_a = 1'b1;
    quies_a = 1'b0;
    expect_at(0, 60,  "gate_block1", 0, 1, 0, 0, 2'd2);
    expect_at(0, 80,  "gate_block2", 0, 1, 0, 0, 2'd2);
    expect_at(0, 100, "gate_block3", 0, 1, 0, 0, 2'd2);
    at_edge(104);
    quies_a = 1'b1;
    expect_at(0, 104, "gate_pre",    0, 1, 0, 0, 2'd2);
    expect_at(0, 105, "gated",       0, 0, 1, 0, 2'd3);
    expect_at(0, 110, "gated_noq",   0, 0, 1, 0, 2'd3);
    at_edge(107);
    quies_a = 1'b0;
    at_edge(112);
    sw_a = 1'b1;
    quies_a = 1'b1;
    expect_at(0, 113, "gsw_hold",    1, 1, 0, 0, 2'd1);
    expect_at(0, 128, "gsw_hold_end",1, 1, 0, 0, 2'd1);
    expect_at(0, 129, "gsw_run",     0, 1, 0, 1, 2'd2);
    expect_at(0, 130, "gsw_regate",  0, 0, 1, 1, 2'd3);
    expect_at(0, 133, "gsw_ack_clr", 0, 0, 1, 0, 2'd3);
    expect_at(0, 135, "ungate_pre",  0, 0, 1, 0, 2'd3);
    expect_at(0, 136, "ungate",      0, 1, 0, 0, 2'd2);
    at_edge(132);
    sw_a = 1'b0;
    at_edge(135);
    gate_a = 1'b0;
    at_edge(140);
    sw_a = 1'b1;
    expect_at(0, 141, "drop_hold",   1, 1, 0, 0, 2'd1);
    expect_at(0, 157, "drop_noack",  0, 1, 0, 0, 2'd2);
    expect_at(0, 160, "drop_run",    0, 1, 0, 0, 2'd2);
    at_edge(145);
    sw_a = 1'b0;
    at_edge(165);
    sw_a = 1'b1;
    at_edge(174);
    rst_a = 1'b0;
    sw_a = 1'b0;
    expect_at(0, 174, "async_rst",   1, 1, 0, 0, 2'd0);
    expect_at(0, 175, "async_held",  1, 1, 0, 0, 2'd0);
    expect_at(0, 178, "re_assert",   1, 1, 0, 0, 2'd0);
    expect_at(0, 179, "re_hold",     1, 1, 0, 0, 2'd1);
    expect_at(0, 194, "re_hold_end", 1, 1, 0, 0, 2'd1);
    expect_at(0, 195, "re_run",      0, 1, 0, 0, 2'd2);
    at_edge(175);
    rst_a = 1'b1;
    at_edge(200);
    check_clk("clk_pass_hi");
    #5;
    check_clk("clk_pass_lo");
    foreach (q[i]) begin
      errors++;
      checks++;
      $display("FAIL %s dut%0d cyc%0d: got no observation, want one", q[i].name, q[i].id, q[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    expect_at(1, 4,  "min_assert",  1, 1, 0, 0, 2'd0);
    expect_at(1, 5,  "min_hold",    1, 1, 0, 0, 2'd1);
    expect_at(1, 6,  "min_run",     0, 1, 0, 0, 2'd2);
    at_edge(2);
    rst_b = 1'b1;
    at_edge(20);
    sw_b = 1'b1;
    expect_at(1, 21, "min_sw_hold", 1, 1, 0, 0, 2'd1);
    expect_at(1, 22, "min_sw_ack",  0, 1, 0, 1, 2'd2);
    expect_at(1, 25, "min_ack_clr", 0, 1, 0, 0, 2'd2);
    at_edge(24);
    sw_b = 1'b0;
  end
  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clock_group_reset_source.md
# clock_group_reset_source

Producer end of the subsystem_cbus clock-group member bundle: generates the `clock`/`reset` pair that clock-group pass-through nodes consume and forward to the cbus domain. The block synchronizes the chip-level reset for safe release and stretches the member reset. It also supports a software-requested domain reset (req/ack) and a quiescence-qualified clock-enable gate (req/ack). It sits between the top-level reset/clock source and the cbus clock group.

## Interface
Parameters:
- `SYNC_STAGES`, 3, reset synchronizer depth (legal 2..4)
- `RESET_HOLD`, 16, cycles the member reset is held after sync release or software request (legal 1..255)

Ports:
- `clock`  in  1  block clock; one clock; reset is asynchronous and active-low
- `reset`  in  1  asynchronous, active-low reset
- `io_swReset_req`  in  1  level request for a member-domain reset
- `io_swReset_ack`  out  1  request completed; held until req drops
- `io_gate_req`  in  1  level request to disable the member clock enable
- `io_quiescent`  in  1  member domain idle indication
- `io_gate_ack`  out  1  high while gated
- `io_state`  out  2  FSM state for debug
- `auto_out_member_subsystem_cbus_0_clock`  out  1  equals `clock`, pass-through, no logic
- `auto_out_member_subsystem_cbus_0_reset`  out  1  active-high member reset
- `auto_out_member_subsystem_cbus_0_clock_en`  out  1  member clock enable, feeds the downstream ICG

## Operation
- Sync chain: `reset` low asynchronously clears all SYNC_STAGES flops. Each rising edge shifts in 1. `rst_sync` is the last stage.
- FSM states: ASSERT=0, HOLD=1, RUN=2, GATED=3.
  - Outputs decode from state and ack flops only.
  - ASSERT: member reset=1, clock_en=1.
  - HOLD: member reset=1, clock_en=1.
  - RUN: member reset=0, clock_en=1.
  - GATED: member reset=0, clock_en=0, gate_ack=1.
- Async reset low: state=ASSERT, counter=0, both acks=0, sw_pending=0. Takes effect immediately without a clock.
- ASSERT → HOLD when rst_sync=1. Counter loads RESET_HOLD-1.
- HOLD: counter decrements each cycle. When counter==0, transition to RUN. HOLD therefore lasts exactly RESET_HOLD cycles.
- RUN, priority order:
  1. swReset_req=1 and ack=0 → HOLD. Counter reloads and sw_pending=1.
  2. gate_req=1 and quiescent=1 → GATED.
  3. Otherwise stay in RUN.
- GATED:
  - swReset_req=1 and ack=0 → HOLD, with clock_en restored. The software reset takes priority.
  - Else gate_req=0 → RUN.
  - quiescent is ignored while gated.
- swReset_ack:
  - Set on the HOLD→RUN edge if sw_pending=1 and req=1. sw_pending clears on that edge.
  - Cleared the cycle after req is sampled low.
  - If req drops during HOLD, the hold completes, ack never rises, and sw_pending clears.
  - While ack=1, req is not re-accepted.
- gate_req without quiescent: stay in RUN indefinitely, with gate_ack=0.
- After a software reset, if gate_req is still high, the block re-gates through RUN once quiescent=1. It spends a minimum of one RUN cycle first.

## Timing
- Power-on: member reset deasserts on edge SYNC_STAGES+1+RESET_HOLD after `reset` rises. The default is edge 20.
- Software reset:
  - req sampled high in RUN at edge N → member reset=1 after edge N.
  - Member reset=0 and ack=1 after edge N+RESET_HOLD.
- Gate: gate_req&quiescent sampled at edge N → clock_en=0 and gate_ack=1 after edge N.
- Ungate: gate_req sampled low at edge N → clock_en=1 and gate_ack=0 after edge N.
- `reset` asserted mid-HOLD or mid-GATED: member reset=1 and clock_en=1 immediately (asynchronous), then the full power-on sequence.
- All outputs are glitch-free (registered decode). There is no combinational path from inputs to outputs, except the clock pass-through.

## Test plan
- Power-on: release `reset` at edge 0 with defaults → member reset high through edge 19, low after edge 20; clock_en=1 throughout.
- Software reset: in RUN, raise req at edge 100 → reset high at edges 101–116, ack=1 after edge 116; drop req at 120 → ack=0 after edge 121; req held high does not retrigger.
- Gate blocked: gate_req=1 with quiescent=0 for 50 cycles → state stays RUN, clock_en=1; quiescent=1 at edge 60 → clock_en=0 and gate_ack=1 after edge 60.
- Software reset while gated: in GATED, raise swReset_req → clock_en=1 next cycle, reset held 16 cycles, ack=1, then re-gate after ≥1 RUN cycle with gate_req and quiescent still high.
- Async reset mid-HOLD (counter=7): drop `reset` between edges → member reset=1, acks=0, io_state=0 without a clock edge; release → 20-edge sequence repeats.
- Parameter sweep: SYNC_STAGES=2, RESET_HOLD=1 → power-on release after edge 4; software reset holds member reset exactly 1 cycle.
